// File: rtl/mano_pkg.sv
// Shared encodings for the Mano basic-computer control unit: timing steps,
// bus sources, ALU operations, opcodes and the control-strobe bundle.
package mano_pkg;

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
  } t_state_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
    BUS_AC   = 3'd4, BUS_IR = 3'd5, BUS_TR = 3'd6, BUS_MEM = 3'd7
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0, ALU_AND = 3'd1, ALU_ADD = 3'd2, ALU_XFER_DR = 3'd3,
    ALU_COM  = 3'd4, ALU_SHR = 3'd5, ALU_SHL = 3'd6
  } alu_op_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  typedef struct packed {
    logic ar_ld;  logic ar_inc; logic ar_clr;
    logic pc_ld;  logic pc_inc;
    logic dr_ld;  logic dr_inc;
    logic ac_ld;  logic ac_inc; logic ac_clr;
    logic ir_ld;
    logic mem_rd; logic mem_wr;
    logic e_clr;  logic e_com;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = 15'd0;

  // Skip tests of a register-reference word all fold into a single PC increment.
  function automatic logic skip_taken(input logic [11:0] field, input logic ac_sign,
                                      input logic ac_zero, input logic e_flag);
    return (field[4] & ~ac_sign) | (field[3] & ac_sign) |
           (field[2] & ac_zero)  | (field[1] & ~e_flag);
  endfunction

endpackage

// File: rtl/mano_control_unit_if.sv
// Datapath <-> control-unit signal bundle: instruction/status in, strobes out.
interface mano_control_unit_if #(parameter int DW = 16);
  logic [DW-1:0] ir;
  logic          ac_sign, ac_zero, e_flag, dr_zero;
  logic [2:0]    bus_sel;
  logic          ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, dr_ld, dr_inc;
  logic          ac_ld, ac_inc, ac_clr, ir_ld;
  logic          mem_rd, mem_wr, e_clr, e_com;
  logic [2:0]    alu_op;
  logic [2:0]    t_state;
  logic          halted;

  modport slave (
    input  ir, ac_sign, ac_zero, e_flag, dr_zero,
    output bus_sel, ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, dr_ld, dr_inc,
           ac_ld, ac_inc, ac_clr, ir_ld, mem_rd, mem_wr, e_clr, e_com,
           alu_op, t_state, halted
  );

  modport master (
    output ir, ac_sign, ac_zero, e_flag, dr_zero,
    input  bus_sel, ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, dr_ld, dr_inc,
           ac_ld, ac_inc, ac_clr, ir_ld, mem_rd, mem_wr, e_clr, e_com,
           alu_op, t_state, halted
  );
endinterface

// File: rtl/mano_seq_counter.sv
// 3-bit timing-step counter; clear has priority over increment.
module mano_seq_counter
  import mano_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_inc,
  input  logic     i_clr,
  output t_state_e o_count
);

  t_state_e r_count;

  // Step register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_count <= T0;
    else if (i_clr) r_count <= T0;
    else if (i_inc) r_count <= t_state_e'(r_count + 3'd1);
    else            r_count <= r_count;
  end

  assign o_count = r_count;

endmodule

// File: rtl/mano_control_unit.sv
// Hardwired control unit of the Mano basic computer: fetch, indirect, memory-
// and register-reference execution decoded from the timing step and latched IR.
module mano_control_unit
  import mano_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic clk,
  input  logic reset,
  mano_control_unit_if.slave cu
);

  t_state_e   w_t;
  logic       w_inc, w_clr, w_halt_set;
  bus_sel_e   w_bus;
  alu_op_e    w_alu;
  ctrl_t      w_ctl;
  logic       r_i;
  logic [2:0] r_d;
  logic [11:0] r_field;
  logic       r_halted;

  mano_seq_counter u_seq (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_inc),
    .i_clr   (w_clr),
    .o_count (w_t)
  );

  // Instruction fields captured at the end of T2, and the sticky halt flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_i      <= 1'b0;
      r_d      <= 3'd0;
      r_field  <= 12'd0;
      r_halted <= 1'b0;
    end else begin
      if (!r_halted && (w_t == T2)) begin
        r_i     <= cu.ir[DW-1];
        r_d     <= cu.ir[DW-2 -: 3];
        r_field <= cu.ir[11:0];
      end
      if (w_halt_set) r_halted <= 1'b1;
    end
  end

  // Next-step and control-strobe decode; everything stays idle in reset or halt
  always_comb begin
    w_bus      = BUS_NONE;
    w_alu      = ALU_NONE;
    w_ctl      = CTRL_IDLE;
    w_inc      = 1'b0;
    w_clr      = 1'b0;
    w_halt_set = 1'b0;
    if (!reset || r_halted) begin
      w_ctl = CTRL_IDLE;
    end else begin
      case (w_t)
        T0: begin w_bus = BUS_PC;  w_ctl.ar_ld = 1'b1; w_inc = 1'b1; end
        T1: begin
          w_bus = BUS_MEM; w_ctl.mem_rd = 1'b1; w_ctl.ir_ld = 1'b1;
          w_ctl.pc_inc = 1'b1; w_inc = 1'b1;
        end
        T2: begin w_bus = BUS_IR;  w_ctl.ar_ld = 1'b1; w_inc = 1'b1; end
        T3: begin
          if (r_d == OP_REG) begin
            w_clr = 1'b1;
            if (!r_i) begin
              if (r_field[11])     w_ctl.ac_clr = 1'b1;
              else if (r_field[9]) begin w_alu = ALU_COM; w_ctl.ac_ld = 1'b1; end
              else if (r_field[7]) begin w_alu = ALU_SHR; w_ctl.ac_ld = 1'b1; end
              else if (r_field[6]) begin w_alu = ALU_SHL; w_ctl.ac_ld = 1'b1; end
              else if (r_field[5]) w_ctl.ac_inc = 1'b1;
              else                 w_ctl.ac_inc = 1'b0;
              if (r_field[10])     w_ctl.e_clr = 1'b1;
              else if (r_field[8]) w_ctl.e_com = 1'b1;
              else                 w_ctl.e_clr = 1'b0;
              w_ctl.pc_inc = skip_taken(r_field, cu.ac_sign, cu.ac_zero, cu.e_flag);
              w_halt_set   = r_field[0];
            end else begin
              w_halt_set = 1'b0;
            end
          end else begin
            w_inc = 1'b1;
            if (r_i) begin
              w_bus = BUS_MEM; w_ctl.mem_rd = 1'b1; w_ctl.ar_ld = 1'b1;
            end else begin
              w_bus = BUS_NONE;
            end
          end
        end
        T4: begin
          case (r_d)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              w_bus = BUS_MEM; w_ctl.mem_rd = 1'b1; w_ctl.dr_ld = 1'b1; w_inc = 1'b1;
            end
            OP_STA: begin w_bus = BUS_AC; w_ctl.mem_wr = 1'b1; w_clr = 1'b1; end
            OP_BUN: begin w_bus = BUS_AR; w_ctl.pc_ld = 1'b1;  w_clr = 1'b1; end
            OP_BSA: begin
              w_bus = BUS_PC; w_ctl.mem_wr = 1'b1; w_ctl.ar_inc = 1'b1; w_inc = 1'b1;
            end
            default: w_clr = 1'b1;
          endcase
        end
        T5: begin
          case (r_d)
            OP_AND: begin w_alu = ALU_AND;     w_ctl.ac_ld = 1'b1; w_clr = 1'b1; end
            OP_ADD: begin w_alu = ALU_ADD;     w_ctl.ac_ld = 1'b1; w_clr = 1'b1; end
            OP_LDA: begin w_alu = ALU_XFER_DR; w_ctl.ac_ld = 1'b1; w_clr = 1'b1; end
            OP_BSA: begin w_bus = BUS_AR; w_ctl.pc_ld = 1'b1; w_clr = 1'b1; end
            OP_ISZ: begin w_ctl.dr_inc = 1'b1; w_inc = 1'b1; end
            default: w_clr = 1'b1;
          endcase
        end
        T6: begin
          w_clr = 1'b1;
          if (r_d == OP_ISZ) begin
            w_bus = BUS_DR; w_ctl.mem_wr = 1'b1; w_ctl.pc_inc = cu.dr_zero;
          end else begin
            w_bus = BUS_NONE;
          end
        end
        default: w_clr = 1'b1;
      endcase
    end
  end

  assign cu.bus_sel = w_bus;
  assign cu.alu_op  = w_alu;
  assign cu.t_state = w_t;
  assign cu.halted  = r_halted;
  assign cu.ar_ld   = w_ctl.ar_ld;
  assign cu.ar_inc  = w_ctl.ar_inc;
  assign cu.ar_clr  = w_ctl.ar_clr;
  assign cu.pc_ld   = w_ctl.pc_ld;
  assign cu.pc_inc  = w_ctl.pc_inc;
  assign cu.dr_ld   = w_ctl.dr_ld;
  assign cu.dr_inc  = w_ctl.dr_inc;
  assign cu.ac_ld   = w_ctl.ac_ld;
  assign cu.ac_inc  = w_ctl.ac_inc;
  assign cu.ac_clr  = w_ctl.ac_clr;
  assign cu.ir_ld   = w_ctl.ir_ld;
  assign cu.mem_rd  = w_ctl.mem_rd;
  assign cu.mem_wr  = w_ctl.mem_wr;
  assign cu.e_clr   = w_ctl.e_clr;
  assign cu.e_com   = w_ctl.e_com;

endmodule

// File: tb/tb_mano_control_unit.sv
// Directed bench: a small register/memory datapath runs a hand-written program
// under the control unit; strobes and register results are checked per step.
module tb_mano_control_unit;

  localparam logic [14:0] S_AR_LD = 15'h4000, S_AR_INC = 15'h2000, S_AR_CLR = 15'h1000;
  localparam logic [14:0] S_PC_LD = 15'h0800, S_PC_INC = 15'h0400;
  localparam logic [14:0] S_DR_LD = 15'h0200, S_DR_INC = 15'h0100;
  localparam logic [14:0] S_AC_LD = 15'h0080, S_AC_INC = 15'h0040, S_AC_CLR = 15'h0020;
  localparam logic [14:0] S_IR_LD = 15'h0010, S_MEM_RD = 15'h0008, S_MEM_WR = 15'h0004;
  localparam logic [14:0] S_E_CLR = 15'h0002, S_E_COM  = 15'h0001;
  localparam logic [14:0] S_NONE  = 15'h0000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mano_control_unit_if #(.DW(16)) bus_if ();

  mano_control_unit #(.DW(16)) dut (.clk(clk), .reset(reset), .cu(bus_if));

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];
  logic [11:0] m_ar, m_pc;
  logic [15:0] m_dr, m_ac, m_ir;
  logic        m_e;
  logic [15:0] w_bus_val, w_alu_val;
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = 12'd0;
  logic [15:0] poke_data = 16'd0;
  logic [14:0] w_strb;

  assign w_strb = {bus_if.ar_ld, bus_if.ar_inc, bus_if.ar_clr, bus_if.pc_ld, bus_if.pc_inc,
                   bus_if.dr_ld, bus_if.dr_inc, bus_if.ac_ld, bus_if.ac_inc, bus_if.ac_clr,
                   bus_if.ir_ld, bus_if.mem_rd, bus_if.mem_wr, bus_if.e_clr, bus_if.e_com};

  assign bus_if.ir      = m_ir;
  assign bus_if.ac_sign = m_ac[15];
  assign bus_if.ac_zero = (m_ac == 16'd0);
  assign bus_if.e_flag  = m_e;
  assign bus_if.dr_zero = (m_dr == 16'd0);

  always_comb begin
    case (bus_if.bus_sel)
      3'd1:    w_bus_val = {4'h0, m_ar};
      3'd2:    w_bus_val = {4'h0, m_pc};
      3'd3:    w_bus_val = m_dr;
      3'd4:    w_bus_val = m_ac;
      3'd5:    w_bus_val = m_ir;
      3'd7:    w_bus_val = mem[m_ar];
      default: w_bus_val = 16'd0;
    endcase
    case (bus_if.alu_op)
      3'd1:    w_alu_val = m_ac & m_dr;
      3'd2:    w_alu_val = m_ac + m_dr;
      3'd3:    w_alu_val = m_dr;
      3'd4:    w_alu_val = ~m_ac;
      3'd5:    w_alu_val = {m_e, m_ac[15:1]};
      3'd6:    w_alu_val = {m_ac[14:0], m_e};
      default: w_alu_val = m_ac;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ar <= 12'd0; m_pc <= 12'd0; m_dr <= 16'd0; m_ac <= 16'd0; m_ir <= 16'd0; m_e <= 1'b0;
    end else begin
      if (bus_if.ar_ld) m_ar <= w_bus_val[11:0];
      else if (bus_if.ar_inc) m_ar <= m_ar + 12'd1;
      else if (bus_if.ar_clr) m_ar <= 12'd0;
      if (bus_if.pc_ld) m_pc <= w_bus_val[11:0];
      else if (bus_if.pc_inc) m_pc <= m_pc + 12'd1;
      if (bus_if.dr_ld) m_dr <= w_bus_val;
      else if (bus_if.dr_inc) m_dr <= m_dr + 16'd1;
      if (bus_if.ac_ld) m_ac <= w_alu_val;
      else if (bus_if.ac_inc) m_ac <= m_ac + 16'd1;
      else if (bus_if.ac_clr) m_ac <= 16'd0;
      if (bus_if.ir_ld) m_ir <= w_bus_val;
      if (bus_if.e_clr) m_e <= 1'b0;
      else if (bus_if.e_com) m_e <= ~m_e;
    end
  end

  always_ff @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (bus_if.mem_wr) mem[m_ar] <= w_bus_val;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_step(input string tag, input logic [2:0] t, input logic [2:0] bsel,
                             input logic [2:0] alu, input logic [14:0] strb);
    check_eq({tag, "/t_state"}, {29'd0, bus_if.t_state}, {29'd0, t});
    check_eq({tag, "/bus_sel"}, {29'd0, bus_if.bus_sel}, {29'd0, bsel});
    check_eq({tag, "/alu_op"},  {29'd0, bus_if.alu_op},  {29'd0, alu});
    check_eq({tag, "/strobes"}, {17'd0, w_strb},         {17'd0, strb});
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  // Runs T0..T2 with checks and leaves the bench in T3.
  task automatic fetch(input string tag);
    expect_step({tag, "/T0"}, 3'd0, 3'd2, 3'd0, S_AR_LD);
    tick();
    expect_step({tag, "/T1"}, 3'd1, 3'd7, 3'd0, S_MEM_RD | S_IR_LD | S_PC_INC);
    tick();
    expect_step({tag, "/T2"}, 3'd2, 3'd5, 3'd0, S_AR_LD);
    tick();
  endtask

  initial begin
    tick();
    expect_step("reset", 3'd0, 3'd0, 3'd0, S_NONE);
    check_eq("reset/halted", {31'd0, bus_if.halted}, 32'd0);
    poke(12'h000, 16'h2005); poke(12'h001, 16'h9010); poke(12'h002, 16'h6020);
    poke(12'h003, 16'h7001); poke(12'h004, 16'h4200); poke(12'h005, 16'h1234);
    poke(12'h010, 16'h0040); poke(12'h040, 16'h0001); poke(12'h020, 16'hFFFF);
    poke(12'h200, 16'h6020); poke(12'h201, 16'h5100); poke(12'h101, 16'h7800);
    poke(12'h102, 16'h7004); poke(12'h103, 16'h7001); poke(12'h104, 16'h7740);
    poke(12'h105, 16'h7008); poke(12'h106, 16'h7001); poke(12'h107, 16'h7001);
    reset = 1'b1;
    #1;

    fetch("lda");
    expect_step("lda/T3", 3'd3, 3'd0, 3'd0, S_NONE); tick();
    expect_step("lda/T4", 3'd4, 3'd7, 3'd0, S_MEM_RD | S_DR_LD); tick();
    expect_step("lda/T5", 3'd5, 3'd0, 3'd3, S_AC_LD); tick();
    check_eq("lda/ac", {16'd0, m_ac}, 32'h1234);
    check_eq("lda/pc", {20'd0, m_pc}, 32'h1);

    fetch("addi");
    expect_step("addi/T3", 3'd3, 3'd7, 3'd0, S_MEM_RD | S_AR_LD); tick();
    expect_step("addi/T4", 3'd4, 3'd7, 3'd0, S_MEM_RD | S_DR_LD); tick();
    expect_step("addi/T5", 3'd5, 3'd0, 3'd2, S_AC_LD); tick();
    check_eq("addi/ac", {16'd0, m_ac}, 32'h1235);

    fetch("isz1");
    expect_step("isz1/T3", 3'd3, 3'd0, 3'd0, S_NONE); tick();
    expect_step("isz1/T4", 3'd4, 3'd7, 3'd0, S_MEM_RD | S_DR_LD); tick();
    expect_step("isz1/T5", 3'd5, 3'd0, 3'd0, S_DR_INC); tick();
    expect_step("isz1/T6", 3'd6, 3'd3, 3'd0, S_MEM_WR | S_PC_INC); tick();
    check_eq("isz1/pc", {20'd0, m_pc}, 32'h4);
    check_eq("isz1/mem", {16'd0, mem[12'h020]}, 32'h0);

    fetch("bun");
    expect_step("bun/T3", 3'd3, 3'd0, 3'd0, S_NONE); tick();
    expect_step("bun/T4", 3'd4, 3'd1, 3'd0, S_PC_LD); tick();
    check_eq("bun/pc", {20'd0, m_pc}, 32'h200);

    poke_en = 1'b1; poke_addr = 12'h020; poke_data = 16'h0003;
    fetch("isz2");
    poke_en = 1'b0;
    expect_step("isz2/T3", 3'd3, 3'd0, 3'd0, S_NONE); tick();
    expect_step("isz2/T4", 3'd4, 3'd7, 3'd0, S_MEM_RD | S_DR_LD); tick();
    expect_step("isz2/T5", 3'd5, 3'd0, 3'd0, S_DR_INC); tick();
    expect_step("isz2/T6", 3'd6, 3'd3, 3'd0, S_MEM_WR); tick();
    check_eq("isz2/pc", {20'd0, m_pc}, 32'h201);
    check_eq("isz2/mem", {16'd0, mem[12'h020]}, 32'h4);

    fetch("bsa");
    expect_step("bsa/T3", 3'd3, 3'd0, 3'd0, S_NONE); tick();
    expect_step("bsa/T4", 3'd4, 3'd2, 3'd0, S_MEM_WR | S_AR_INC); tick();
    expect_step("bsa/T5", 3'd5, 3'd1, 3'd0, S_PC_LD); tick();
    check_eq("bsa/t0", {29'd0, bus_if.t_state}, 32'd0);
    check_eq("bsa/pc", {20'd0, m_pc}, 32'h101);
    check_eq("bsa/ret", {16'd0, mem[12'h100]}, 32'h202);

    fetch("cla");
    expect_step("cla/T3", 3'd3, 3'd0, 3'd0, S_AC_CLR); tick();
    check_eq("cla/ac", {16'd0, m_ac}, 32'h0);

    fetch("sza");
    expect_step("sza/T3", 3'd3, 3'd0, 3'd0, S_PC_INC); tick();
    check_eq("sza/pc", {20'd0, m_pc}, 32'h104);

    fetch("prio");
    expect_step("prio/T3", 3'd3, 3'd0, 3'd4, S_AC_LD | S_E_CLR); tick();
    check_eq("prio/ac", {16'd0, m_ac}, 32'hFFFF);

    fetch("sna");
    expect_step("sna/T3", 3'd3, 3'd0, 3'd0, S_PC_INC); tick();
    check_eq("sna/pc", {20'd0, m_pc}, 32'h107);

    fetch("hlt");
    expect_step("hlt/T3", 3'd3, 3'd0, 3'd0, S_NONE);
    check_eq("hlt/T3 halted", {31'd0, bus_if.halted}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_step("hlt/hold", 3'd0, 3'd0, 3'd0, S_NONE);
      check_eq("hlt/halted", {31'd0, bus_if.halted}, 32'd1);
    end
    check_eq("hlt/pc", {20'd0, m_pc}, 32'h108);

    reset = 1'b0;
    #1;
    check_eq("rst/halted clr", {31'd0, bus_if.halted}, 32'd0);
    poke(12'h000, 16'h6020);
    reset = 1'b1;
    #1;
    fetch("rsti");
    expect_step("rsti/T3", 3'd3, 3'd0, 3'd0, S_NONE); tick();
    expect_step("rsti/T4", 3'd4, 3'd7, 3'd0, S_MEM_RD | S_DR_LD); tick();
    expect_step("rsti/T5", 3'd5, 3'd0, 3'd0, S_DR_INC);
    reset = 1'b0;
    #1;
    expect_step("rsti/midreset", 3'd0, 3'd0, 3'd0, S_NONE);
    tick();
    expect_step("rsti/held", 3'd0, 3'd0, 3'd0, S_NONE);
    reset = 1'b1;
    #1;
    expect_step("rsti/release", 3'd0, 3'd2, 3'd0, S_AR_LD);
    tick();
    check_eq("rsti/T1", {29'd0, bus_if.t_state}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
